// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the single write port of a negedge-capturing register bank
//   clk      : arbitration on posedge; the bank captures on negedge
//   reset    : asynchronous, active-low; clears grant, write enable, data and pointer
//   stall    : high blocks new grants this cycle
//   req      : per-requester request bits
//   req_addr : per-requester destination register, slice [i*ADDR_W +: ADDR_W]
//   req_data : per-requester write data, slice [i*DATA_W +: DATA_W]
//   gnt      : registered one-hot grant
//   wr_en    : registered one-hot per-register write enable
//   wr_data  : registered shared data bus to every register
//   busy     : high while a grant is outstanding (|gnt)
// Optional: define REGFILE_WRITE_ARBITER_R0_ZERO_EN to make register 0 hardwired zero.
module regfile_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [(2**ADDR_W)-1:0]   wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy
);
  localparam int PW    = $clog2(NREQ);
  localparam int NREGS = 2**ADDR_W;
  logic [PW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [NREGS-1:0]  r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_next_ptr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_take;
  logic              w_wr;
  // Circular search starting at the pointer; the first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[(int'(r_ptr) + i) % NREQ]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_ptr) + i) % NREQ);
      end
    end
  end
  assign w_next_ptr = (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;
  assign w_addr     = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
  assign w_data     = req_data[int'(w_win)*DATA_W +: DATA_W];
  assign w_take     = w_found && !stall;
`ifdef REGFILE_WRITE_ARBITER_R0_ZERO_EN
  // A write to register 0 is granted and consumes its turn but never reaches the bank.
  assign w_wr = w_take && (w_addr != '0);
`else
  assign w_wr = w_take;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_wr_en   <= '0;
      r_wr_data <= '0;
    end else begin
      r_gnt   <= w_take ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;
      r_wr_en <= w_wr ? ({{(NREGS-1){1'b0}}, 1'b1} << w_addr) : '0;
      if (w_wr) r_wr_data <= w_data;
      if (w_take) r_ptr <= w_next_ptr;
    end
  end
  assign gnt     = r_gnt;
  assign wr_en   = r_wr_en;
  assign wr_data = r_wr_data;
  assign busy    = |r_gnt;
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the register bank between NREQ requesters, using round-robin arbitration.
- The bank is built from falling-edge flip-flops with write enables (d, w, clk, q); those flip-flops capture on negedge clk.
- This block decides on posedge clk. It drives the per-register w enables and the shared d bus, which stay stable for a half cycle before the capturing negedge.
- It sits between the CPU write-back sources (ALU, load unit, etc.) and the register bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width; bank holds 2**ADDR_W registers.

Ports:
- clk  input  1  system clock; arbitration on posedge, bank capture on negedge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  high: no new grants this cycle.
- req  input  NREQ  request bit i from requester i.
- req_addr  input  NREQ*ADDR_W  destination register; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  write data; requester i uses slice [i*DATA_W +: DATA_W].
- gnt  output  NREQ  one-hot grant, registered.
- wr_en  output  2**ADDR_W  one-hot write enable; bit k drives w of register k, registered.
- wr_data  output  DATA_W  shared d bus to every register, registered.
- busy  output  1  high while a grant is outstanding this cycle (equals |gnt).

Behaviour:
- Reset (reset=0, asynchronous, any time):
  - gnt=0, wr_en=0, wr_data=0, busy=0.
  - Round-robin pointer ptr=0.
  - Asserting reset mid-cycle cancels the write pending for the next negedge.
- Release: first arbitration happens at the first posedge with reset=1.
- Each posedge, when stall=0 and req!=0:
  - Winner w = first set bit of req, searching circularly from ptr upward (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - gnt <= one-hot(w); wr_en <= one-hot(req_addr[w]); wr_data <= req_data[w].
  - ptr <= (w+1) mod NREQ.
- Each posedge, when stall=1 or req==0:
  - gnt<=0, wr_en<=0, wr_data holds its previous value, ptr holds.
- Latency:
  - req sampled at posedge N gives gnt/wr_en high during cycle N.
  - The bank writes on the negedge inside cycle N.
  - The data is visible on the bank q outputs from that negedge onward.
- Grant meaning: gnt=1 for one cycle means the write is accepted and completes at that cycle's negedge.
  - A requester keeping req=1 across the next posedge is treated as a new, separate request.
- At most one gnt bit and one wr_en bit are high in any cycle; the write port is exclusive.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0,... and each requester is served once per NREQ cycles.
- Same-address requests from different requesters are serialized in round-robin order; the last one granted wins.
- Inputs (req, req_addr, req_data, stall) must be stable around posedge only; the block never samples on negedge.
- Pointer wrap: a winner at NREQ-1 sets ptr=0.

Optional Feature:
- Macro: REGFILE_WRITE_ARBITER_R0_ZERO_EN.
- Defined: register 0 is hardwired zero.
  - A winning request to address 0 still receives gnt and still advances ptr.
  - wr_en stays all-zero and wr_data is not updated.
  - No write reaches register 0.
- Undefined: address 0 is an ordinary writable register.

Test Plan:
- Reset then single request: reset=0 for 2 cycles, then release; req=4'b0010, req_addr[1]=5, req_data[1]=16'hBEEF for one posedge -> that cycle gnt=4'b0010, wr_en=8'b0010_0000, wr_data=16'hBEEF; register 5 q=16'hBEEF after the negedge; ptr=2.
- Full contention: req=4'b1111 held for 8 cycles from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; exactly one wr_en bit high each cycle.
- Stall: req=4'b0101, stall=1 for 3 cycles -> gnt=0, wr_en=0, ptr unchanged; stall=0 -> gnt=4'b0001, then 4'b0100.
- Same address: req=4'b0011, both targeting addr 3 with data 16'h1111 (req0) and 16'h2222 (req1), ptr=0 -> register 3 = 16'h1111 after cycle 1, then 16'h2222 after cycle 2.
- Reset mid-operation: assert reset=0 while gnt=4'b1000 and wr_en high, after posedge and before negedge -> outputs clear immediately; target register keeps its old value; ptr=0.
- Macro defined: req0 writes 16'hFFFF to addr 0 -> gnt=4'b0001, wr_en=0, register 0 stays 0. Macro undefined, same stimulus -> register 0 = 16'hFFFF.
